// File: rtl/complex_fir_sequencer.sv
// complex_fir_sequencer: arms the complex FIR, streams ROM coefficients, gates samples, optionally flushes, then stops.
// Ports: clock/reset (async, active-high); start/numSamples launch a run; coeffAddr -> ROM, coeffRdRe/Im <- ROM
// (one-cycle latency); sampleValid/sampleReady/sampleRe/sampleIm form the sample handshake; firLoadCoeff,
// firLoadDataFlag, firStopDataLoadFlag, firCoeffRe/Im, firDataRe/Im drive the filter; busy/done report status.
// Define FIR_SEQ_FLUSH_EN to append LENGTH zero samples after the last real sample.
module complex_fir_sequencer #(
    parameter int LENGTH           = 12,
    parameter int DATA_WIDTH       = 8,
    parameter int SAMPLE_CNT_WIDTH = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic [SAMPLE_CNT_WIDTH-1:0]        numSamples,
    output logic [$clog2(LENGTH)-1:0]          coeffAddr,
    input  logic signed [DATA_WIDTH-1:0]       coeffRdRe,
    input  logic signed [DATA_WIDTH-1:0]       coeffRdIm,
    input  logic                               sampleValid,
    input  logic signed [3*DATA_WIDTH-1:0]     sampleRe,
    input  logic signed [3*DATA_WIDTH-1:0]     sampleIm,
    output logic                               sampleReady,
    output logic                               firLoadCoeff,
    output logic                               firLoadDataFlag,
    output logic                               firStopDataLoadFlag,
    output logic signed [DATA_WIDTH-1:0]       firCoeffRe,
    output logic signed [DATA_WIDTH-1:0]       firCoeffIm,
    output logic signed [3*DATA_WIDTH-1:0]     firDataRe,
    output logic signed [3*DATA_WIDTH-1:0]     firDataIm,
    output logic                               busy,
    output logic                               done
);
    localparam int AW = $clog2(LENGTH);
    localparam int KW = $clog2(LENGTH + 3);
    typedef enum logic [2:0] {IDLE, ARM, WAIT, COEFF, STREAM, FLUSH, STOP, DONE} state_t;
    state_t                      state;
    state_t                      after_samples;
    logic [KW-1:0]               k;
    logic [SAMPLE_CNT_WIDTH-1:0] remaining;
    logic                        take;
    logic                        coeff_live;
`ifdef FIR_SEQ_FLUSH_EN
    assign after_samples = FLUSH;
`else
    assign after_samples = STOP;
`endif
    assign sampleReady = state == STREAM;
    assign take        = sampleReady && sampleValid;
    // The last three COEFF slots shift zeros into the filter's pre-buffer.
    assign coeff_live  = state == COEFF && k < KW'(LENGTH);
    assign firCoeffRe  = coeff_live ? coeffRdRe : '0;
    assign firCoeffIm  = coeff_live ? coeffRdIm : '0;
    // Outputs are registered one edge after the state that produces them; busy is
    // cleared only by IDLE, so it also covers the cycle in which done is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            k                   <= '0;
            remaining           <= '0;
            coeffAddr           <= '0;
            firLoadCoeff        <= 1'b0;
            firLoadDataFlag     <= 1'b0;
            firStopDataLoadFlag <= 1'b0;
            firDataRe           <= '0;
            firDataIm           <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            firLoadCoeff        <= 1'b0;
            firLoadDataFlag     <= 1'b0;
            firStopDataLoadFlag <= 1'b0;
            done                <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        state        <= ARM;
                        firLoadCoeff <= 1'b1;
                        busy         <= 1'b1;
                        remaining    <= numSamples;
                        k            <= '0;
                        coeffAddr    <= '0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ARM: state <= WAIT;
                WAIT: begin
                    state     <= COEFF;
                    coeffAddr <= AW'(1);
                end
                COEFF: begin
                    // Address runs one ahead of k to cover the ROM read latency, saturating at the last tap.
                    coeffAddr <= (k >= KW'(LENGTH - 3)) ? AW'(LENGTH - 1) : AW'(k + KW'(2));
                    k         <= k + 1'b1;
                    if (k == KW'(LENGTH + 2)) begin
                        k     <= '0;
                        state <= (remaining != '0) ? STREAM : after_samples;
                    end
                end
                STREAM: begin
                    if (take) begin
                        firLoadDataFlag <= 1'b1;
                        firDataRe       <= sampleRe;
                        firDataIm       <= sampleIm;
                        remaining       <= remaining - 1'b1;
                        if (remaining == SAMPLE_CNT_WIDTH'(1)) state <= after_samples;
                    end
                end
`ifdef FIR_SEQ_FLUSH_EN
                FLUSH: begin
                    firLoadDataFlag <= 1'b1;
                    firDataRe       <= '0;
                    firDataIm       <= '0;
                    k               <= k + 1'b1;
                    if (k == KW'(LENGTH - 1)) begin
                        k     <= '0;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    firStopDataLoadFlag <= 1'b1;
                    state               <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_fir_sequencer.sv
// tb_complex_fir_sequencer: randomized run-level checks of complex_fir_sequencer against a cycle-timeline model.
module tb_complex_fir_sequencer;
    localparam int L   = 12;
    localparam int DW  = 8;
    localparam int SCW = 16;
    localparam int SW  = 3 * DW;
`ifdef FIR_SEQ_FLUSH_EN
    localparam bit FL = 1;
`else
    localparam bit FL = 0;
`endif
    logic                  clock = 0;
    logic                  reset = 1;
    logic                  start = 0;
    logic [SCW-1:0]        numSamples = '0;
    logic [$clog2(L)-1:0]  coeffAddr;
    logic signed [DW-1:0]  coeffRdRe = '0;
    logic signed [DW-1:0]  coeffRdIm = '0;
    logic                  sampleValid = 0;
    logic signed [SW-1:0]  sampleRe = '0;
    logic signed [SW-1:0]  sampleIm = '0;
    logic                  sampleReady;
    logic                  firLoadCoeff;
    logic                  firLoadDataFlag;
    logic                  firStopDataLoadFlag;
    logic signed [DW-1:0]  firCoeffRe;
    logic signed [DW-1:0]  firCoeffIm;
    logic signed [SW-1:0]  firDataRe;
    logic signed [SW-1:0]  firDataIm;
    logic                  busy;
    logic                  done;
    logic signed [DW-1:0]  rom_re [L];
    logic signed [DW-1:0]  rom_im [L];
    logic signed [SW-1:0]  m_re = '0;
    logic signed [SW-1:0]  m_im = '0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    complex_fir_sequencer #(.LENGTH(L), .DATA_WIDTH(DW), .SAMPLE_CNT_WIDTH(SCW)) dut (
        .clock(clock), .reset(reset), .start(start), .numSamples(numSamples),
        .coeffAddr(coeffAddr), .coeffRdRe(coeffRdRe), .coeffRdIm(coeffRdIm),
        .sampleValid(sampleValid), .sampleRe(sampleRe), .sampleIm(sampleIm), .sampleReady(sampleReady),
        .firLoadCoeff(firLoadCoeff), .firLoadDataFlag(firLoadDataFlag), .firStopDataLoadFlag(firStopDataLoadFlag),
        .firCoeffRe(firCoeffRe), .firCoeffIm(firCoeffIm), .firDataRe(firDataRe), .firDataIm(firDataIm),
        .busy(busy), .done(done)
    );
    always #5 clock = ~clock;
    always @(posedge clock) begin
        coeffRdRe <= (int'(coeffAddr) < L) ? rom_re[coeffAddr] : '0;
        coeffRdIm <= (int'(coeffAddr) < L) ? rom_im[coeffAddr] : '0;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask
    task automatic chk_zero();
        chk("z_ready", sampleReady, 0);
        chk("z_busy", busy, 0);
        chk("z_done", done, 0);
        chk("z_loadcoeff", firLoadCoeff, 0);
        chk("z_loaddata", firLoadDataFlag, 0);
        chk("z_stop", firStopDataLoadFlag, 0);
        chk("z_addr", coeffAddr, 0);
        chk("z_coeff_re", firCoeffRe, 0);
        chk("z_coeff_im", firCoeffIm, 0);
        chk("z_data_re", firDataRe, 0);
        chk("z_data_im", firDataIm, 0);
    endtask
    // One run: cycle 0 is the cycle start is driven. mode 1 = valid always, 2 = toggling, 0 = random with prob%.
    task automatic run(input int n, input int mode, input int prob, input bit rep);
        int cnt = 0, a = -1, stop_c = -1, done_c = -1, c;
        bit pend = 0, v, fl, ld, rdy, fin = 0;
        logic signed [SW-1:0] p_re = '0, p_im = '0;
        logic signed [DW-1:0] ec_re, ec_im;
        if (n == 0) a = L + 5;
        for (c = 0; c < 3000 && !fin; c++) begin
            cyc = c;
            if (a >= 0) begin
                stop_c = a + 2 + (FL ? L : 0);
                done_c = stop_c + 1;
            end
            start = c == 0 || (rep && (c == 5 || c == done_c));
            numSamples = c == 0 ? SCW'(n) : SCW'($urandom);
            rdy = c >= L + 6 && cnt < n;
            v = !rdy ? 1'($urandom_range(1)) : mode == 1 ? 1'b1 : mode == 2 ? ((c - L - 6) % 2 == 0) : ($urandom_range(99) < prob);
            sampleValid = v;
            sampleRe = SW'($urandom);
            sampleIm = SW'($urandom);
            @(negedge clock);
            fl = FL && a >= 0 && c >= a + 2 && c <= a + L + 1;
            ld = pend || fl;
            if (pend) begin
                m_re = p_re;
                m_im = p_im;
            end else if (fl) begin
                m_re = '0;
                m_im = '0;
            end
            ec_re = (c >= 3 && c < 3 + L) ? rom_re[c-3] : '0;
            ec_im = (c >= 3 && c < 3 + L) ? rom_im[c-3] : '0;
            chk("sampleReady", sampleReady, rdy);
            chk("busy", busy, c >= 1 && (done_c < 0 || c <= done_c));
            chk("done", done, c == done_c);
            chk("firLoadCoeff", firLoadCoeff, c == 1);
            chk("firStop", firStopDataLoadFlag, c == stop_c);
            chk("firLoadData", firLoadDataFlag, ld);
            chk("firDataRe", firDataRe, m_re);
            chk("firDataIm", firDataIm, m_im);
            chk("firCoeffRe", firCoeffRe, ec_re);
            chk("firCoeffIm", firCoeffIm, ec_im);
            if (c >= 2 && c <= L + 5) chk("coeffAddr", coeffAddr, c == 2 ? 0 : (c - 2 < L - 1 ? c - 2 : L - 1));
            pend = 0;
            if (rdy && v) begin
                pend = 1;
                p_re = sampleRe;
                p_im = sampleIm;
                cnt++;
                if (cnt == n) a = c;
            end
            if (done_c >= 0 && c == done_c + 1) fin = 1;
            @(posedge clock);
            #1;
        end
        start = 0;
        sampleValid = 0;
        chk("run_end", fin, 1);
    endtask
    task automatic reset_mid();
        start = 1;
        numSamples = 3;
        @(posedge clock);
        #1;
        start = 0;
        repeat (7) @(posedge clock);
        #1;
        cyc = 8;
        chk("mid_coeff", firCoeffRe, rom_re[5]);
        #2 reset = 1;
        #1;
        chk_zero();
        m_re = '0;
        m_im = '0;
        @(posedge clock);
        #1;
        reset = 0;
        @(negedge clock);
        chk("mid_idle_busy", busy, 0);
        @(posedge clock);
        #1;
    endtask
    initial begin
        for (int j = 0; j < L; j++) begin
            rom_re[j] = DW'(j + 1);
            rom_im[j] = DW'(-(j + 1));
        end
        repeat (3) @(posedge clock);
        #1;
        chk_zero();
        reset = 0;
        @(posedge clock);
        #1;
        run(4, 1, 100, 1);
        run(4, 2, 100, 0);
        run(0, 1, 100, 0);
        reset_mid();
        run(3, 1, 100, 0);
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < L; j++) begin
                rom_re[j] = DW'($urandom);
                rom_im[j] = DW'($urandom);
            end
            run($urandom_range(20, 1), 0, $urandom_range(100, 30), 1'($urandom_range(1)));
        end
        run(0, 0, 50, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/complex_fir_sequencer.md
# complex_fir_sequencer

Sequencing controller for the complex FIR filter (`n_tap_complex_fir`) in the matched-filter datapath. It arms the filter, streams LENGTH complex coefficients from a synchronous coefficient ROM in the exact cycle slots the filter's 3-deep coefficient pre-buffer expects, and gates a valid/ready sample stream into the filter. It then optionally flushes the tap line with zeros and issues the stop flag. It sits between the system-level start/sample source and the filter's flag ports.

## Interface
- `LENGTH`, 12: FIR tap count; must equal the filter's LENGTH.
- `DATA_WIDTH`, 8: coefficient width; sample width is 3*DATA_WIDTH.
- `SAMPLE_CNT_WIDTH`, 16: width of the sample counter and `numSamples`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `start` in 1: begin one run when in IDLE; ignored otherwise.
- `numSamples` in SAMPLE_CNT_WIDTH: samples per run, sampled on accepted `start`.
- `coeffAddr` out clog2(LENGTH): ROM address; registered.
- `coeffRdRe`, `coeffRdIm` in DATA_WIDTH signed: ROM data, valid one cycle after `coeffAddr`.
- `sampleValid` in 1, `sampleRe`/`sampleIm` in 3*DATA_WIDTH signed, `sampleReady` out 1: sample handshake.
- `firLoadCoeff`, `firLoadDataFlag`, `firStopDataLoadFlag` out 1: filter control flags; registered.
- `firCoeffRe`, `firCoeffIm` out DATA_WIDTH signed: coefficients to the filter.
- `firDataRe`, `firDataIm` out 3*DATA_WIDTH signed: samples to the filter; registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of run.

## Operation
- States: IDLE, ARM, WAIT, COEFF, STREAM, FLUSH, STOP, DONE.
- IDLE: `start` → ARM, latch `numSamples`, clear counters.
- ARM (1 cycle): `firLoadCoeff`=1 → WAIT.
- WAIT (1 cycle): mirrors the filter's 1-cycle wait; `coeffAddr`=0 → COEFF.
- COEFF: runs LENGTH+3 cycles, counter k=0..LENGTH+2.
  - `firCoeff` = `coeffRd` while k<LENGTH; otherwise 0. This output is a combinational mux.
  - `coeffAddr` = min(k+1, LENGTH-1).
  - Coefficient j ends in filter tap slot LENGTH-1-j.
  - After k=LENGTH+2: → STREAM if latched count>0. Otherwise → FLUSH, or → STOP when flush is compiled out.
- STREAM: `sampleReady`=1, driven from state only.
  - On valid&&ready: next cycle `firLoadDataFlag`=1 and `firData`=sample.
  - Otherwise `firLoadDataFlag`=0 and `firData` holds its value.
  - Accepting sample number numSamples → FLUSH, or → STOP without flush.
- FLUSH: LENGTH cycles with `firLoadDataFlag`=1 and `firData`=0 → STOP.
- STOP (1 cycle): `firStopDataLoadFlag`=1, `firLoadDataFlag`=0 → DONE.
- DONE (1 cycle): `done`=1 → IDLE.
- No arithmetic on the datapath; the controller only passes values through and multiplexes zeros.

## Timing
- Reset values: every output 0 (`sampleReady`, `busy`, `done`, all flags, `coeffAddr`, `firCoeff*`, `firData*`); state IDLE.
- `start` high in cycle 0:
  - `firLoadCoeff` high in cycle 1.
  - COEFF spans cycles 3..LENGTH+5.
  - `sampleReady` first high in cycle LENGTH+6 (cycle 18 at LENGTH=12).
- Sample-in to `firLoadDataFlag` latency: 1 cycle.
- Filter output for that sample appears 1 cycle later, owned by the filter.
- `sampleReady` drops the cycle after the last sample is accepted. A valid sample presented in that cycle is not consumed.
- `start` asserted while `busy` is ignored. `start` in the DONE cycle is also ignored.
- Asynchronous `reset` mid-run: outputs go to 0 immediately and no stop flag is issued. The integrator resets the filter in parallel.
- Gaps in `sampleValid` stall STREAM indefinitely; there is no timeout.

## Configuration
- `FIR_SEQ_FLUSH_EN` defined:
  - FLUSH state compiled in.
  - LENGTH zero samples follow the last real sample, so the filter emits the full convolution tail.
- Undefined:
  - FLUSH state removed; STREAM (or COEFF when count=0) goes directly to STOP.
  - Output length is numSamples only.

## Test plan
- Reset mid-COEFF (k=5) → all outputs 0 in the same cycle; state IDLE; next `start` runs normally.
- LENGTH=12, ROM holds Re=j+1, Im=-(j+1) → `firCoeff` is 1..12 / -1..-12 in cycles 3..14 and 0 in cycles 15..17; `coeffAddr` sequence is 0,1,..,11,11,11,11.
- numSamples=4, `sampleValid` held high, samples 10,20,30,40 → `firLoadDataFlag` high in cycles 19..22 carrying those values; with flush, 12 zero samples follow in cycles 23..34; `firStopDataLoadFlag` in cycle 35; `done` in cycle 36.
- Same run with `sampleValid` toggling 1,0,1,0 → exactly 4 acceptances; `firLoadDataFlag` mirrors the acceptances one cycle later.
- numSamples=0 → no `sampleReady`; with flush enabled, 12 zero samples then STOP; without flush, STOP in cycle 18.
- `start` re-pulsed in cycles 5 and 36 → both ignored; `busy` stays high until DONE.
